// File: rtl/sb_membank_param.sv
// Switch-block tile: bit-line/word-line programmed config bank driving 2*CHAN_W
// size-2 routing muxes, with readback, completion tracking and a sticky error flag.
module sb_membank_param #(
    parameter int unsigned CHAN_W = 9,
    parameter int unsigned BL_W   = 6,
    parameter int unsigned WL_W   = (4 * CHAN_W + BL_W - 1) / BL_W
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              prog_en,
    input  logic              rd_en,
    input  logic [BL_W-1:0]   bl,
    input  logic [WL_W-1:0]   wl,
    output logic [BL_W-1:0]   bl_rd,
    output logic              cfg_done,
    output logic              cfg_err,
    input  logic [CHAN_W-1:0] chany_top_in,
    input  logic [CHAN_W-1:0] chanx_left_in,
    input  logic [CHAN_W-1:0] top_grid_pin,
    input  logic [CHAN_W-1:0] left_grid_pin,
    output logic [CHAN_W-1:0] chany_top_out,
    output logic [CHAN_W-1:0] chanx_left_out
);

    typedef enum logic {UNCONFIG, CONFIGURED} state_t;

    state_t            state, state_nx;
    logic [BL_W-1:0]   mem [WL_W];
    logic [WL_W-1:0]   row_flag, row_flag_nx;
    logic              wl_zero, wl_multi, wl_onehot;
    logic              proto_err, wr_ok, rd_ok;
    logic [BL_W-1:0]   rd_data;
    logic [4*CHAN_W-1:0] cfg_bits;
    logic [1:0]        sel;

    always_comb begin
        wl_zero     = (wl == '0);
        wl_multi    = !wl_zero && ((wl & (wl - WL_W'(1))) != '0);
        wl_onehot   = !wl_zero && !wl_multi;
        proto_err   = ((prog_en || rd_en) && wl_multi) || (prog_en && rd_en);
        wr_ok       = prog_en && !rd_en && wl_onehot;
        rd_ok       = rd_en && !prog_en && wl_onehot;
        row_flag_nx = wr_ok ? (row_flag | wl) : row_flag;
        rd_data     = '0;
        for (int unsigned r = 0; r < WL_W; r++) begin
            if (wl[r]) rd_data = rd_data | mem[r];
        end
    end

    // Completion is judged on the post-edge flags so cfg_done rises on the final write edge.
    always_comb begin
        state_nx = state;
        case (state)
            UNCONFIG:   if (&row_flag_nx) state_nx = CONFIGURED;
            CONFIGURED: state_nx = CONFIGURED;
            default:    state_nx = UNCONFIG;
        endcase
        cfg_done = (state == CONFIGURED);
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state    <= UNCONFIG;
            row_flag <= '0;
            bl_rd    <= '0;
            cfg_err  <= 1'b0;
            for (int unsigned r = 0; r < WL_W; r++) mem[r] <= '0;
        end else begin
            state    <= state_nx;
            row_flag <= row_flag_nx;
            if (proto_err) cfg_err <= 1'b1;
            if (rd_ok) bl_rd <= rd_data;
            for (int unsigned r = 0; r < WL_W; r++) begin
                if (wr_ok && wl[r]) mem[r] <= bl;
            end
        end
    end

    // Flatten row/column storage into the linear bit order; trailing bits of the last row are not routed.
    always_comb begin
        for (int unsigned b = 0; b < 4 * CHAN_W; b++) begin
            cfg_bits[b] = mem[b / BL_W][b % BL_W];
        end
    end

    always_comb begin
        chany_top_out  = '0;
        chanx_left_out = '0;
        sel            = '0;
        for (int unsigned i = 0; i < CHAN_W; i++) begin
            sel = {cfg_bits[2*i+1], cfg_bits[2*i]};
            case (sel)
                2'b01:   chany_top_out[i] = top_grid_pin[i];
                2'b10:   chany_top_out[i] = chanx_left_in[(CHAN_W - i) % CHAN_W];
                default: chany_top_out[i] = 1'b0;
            endcase
            sel = {cfg_bits[2*(CHAN_W+i)+1], cfg_bits[2*(CHAN_W+i)]};
            case (sel)
                2'b01:   chanx_left_out[i] = chany_top_in[(CHAN_W - i) % CHAN_W];
                2'b10:   chanx_left_out[i] = left_grid_pin[i];
                default: chanx_left_out[i] = 1'b0;
            endcase
        end
        if (!cfg_done) begin
            chany_top_out  = '0;
            chanx_left_out = '0;
        end
    end

endmodule

// File: tb/tb_sb_membank_param.sv
// Bench for sb_membank_param: default instance (9/6/6) and a 4/4/4 instance,
// checked every cycle against a row-array model plus hand-computed literals.
module tb_sb_membank_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pe [2];
    logic        re [2];
    logic [31:0] wl_s [2];
    logic [31:0] bl_s [2];
    logic [31:0] cyt [2];
    logic [31:0] cxl [2];
    logic [31:0] tgp [2];
    logic [31:0] lgp [2];

    logic [5:0] a_rd;  logic a_done, a_err;  logic [8:0] a_top, a_left;
    logic [3:0] b_rd;  logic b_done, b_err;  logic [3:0] b_top, b_left;

    logic [31:0] rows [2][8];
    logic [7:0]  flags [2];
    logic        done [2];
    logic        err [2];
    logic [31:0] rdv [2];

    int  checks = 0;
    int  errors = 0;
    bit  chk_on = 1'b0;

    always #5 clk = ~clk;

    sb_membank_param u_a (
        .prog_clk(clk), .pReset(rst), .prog_en(pe[0]), .rd_en(re[0]),
        .bl(bl_s[0][5:0]), .wl(wl_s[0][5:0]), .bl_rd(a_rd), .cfg_done(a_done), .cfg_err(a_err),
        .chany_top_in(cyt[0][8:0]), .chanx_left_in(cxl[0][8:0]),
        .top_grid_pin(tgp[0][8:0]), .left_grid_pin(lgp[0][8:0]),
        .chany_top_out(a_top), .chanx_left_out(a_left)
    );

    sb_membank_param #(.CHAN_W(4), .BL_W(4)) u_b (
        .prog_clk(clk), .pReset(rst), .prog_en(pe[1]), .rd_en(re[1]),
        .bl(bl_s[1][3:0]), .wl(wl_s[1][3:0]), .bl_rd(b_rd), .cfg_done(b_done), .cfg_err(b_err),
        .chany_top_in(cyt[1][3:0]), .chanx_left_in(cxl[1][3:0]),
        .top_grid_pin(tgp[1][3:0]), .left_grid_pin(lgp[1][3:0]),
        .chany_top_out(b_top), .chanx_left_out(b_left)
    );

    function automatic int cw(int d); return (d == 0) ? 9 : 4; endfunction
    function automatic int bw(int d); return (d == 0) ? 6 : 4; endfunction
    function automatic int ww(int d); return (d == 0) ? 6 : 4; endfunction

    function automatic logic mbit(int d, int b);
        logic [31:0] row;
        row = rows[d][b / bw(d)];
        return row[b % bw(d)];
    endfunction

    function automatic logic [31:0] pick(logic [1:0] s, logic in0, logic in1);
        if (s == 2'b01) return 32'(in0);
        if (s == 2'b10) return 32'(in1);
        return 32'd0;
    endfunction

    function automatic logic [31:0] m_top(int d);
        logic [31:0] o = '0;
        logic [31:0] p;
        int n = cw(d);
        if (!done[d]) return '0;
        for (int i = 0; i < n; i++) begin
            p = pick({mbit(d, 2*i+1), mbit(d, 2*i)}, tgp[d][i], cxl[d][(n - i) % n]);
            o[i] = p[0];
        end
        return o;
    endfunction

    function automatic logic [31:0] m_left(int d);
        logic [31:0] o = '0;
        logic [31:0] p;
        int n = cw(d);
        if (!done[d]) return '0;
        for (int i = 0; i < n; i++) begin
            p = pick({mbit(d, 2*(n+i)+1), mbit(d, 2*(n+i))}, cyt[d][(n - i) % n], lgp[d][i]);
            o[i] = p[0];
        end
        return o;
    endfunction

    function automatic logic [31:0] act_rd(int d);   return (d == 0) ? 32'(a_rd)   : 32'(b_rd);   endfunction
    function automatic logic [31:0] act_top(int d);  return (d == 0) ? 32'(a_top)  : 32'(b_top);  endfunction
    function automatic logic [31:0] act_left(int d); return (d == 0) ? 32'(a_left) : 32'(b_left); endfunction
    function automatic logic act_done(int d); return (d == 0) ? a_done : b_done; endfunction
    function automatic logic act_err(int d);  return (d == 0) ? a_err  : b_err;  endfunction

    task automatic chk(string name, int d, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%h expected=%h", name, d, act, exp);
        end
    endtask

    // Model: a row array updated per the protocol rules on each clock edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                for (int r = 0; r < 8; r++) rows[d][r] <= '0;
                flags[d] <= '0;
                done[d]  <= 1'b0;
                err[d]   <= 1'b0;
                rdv[d]   <= '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                automatic int n = $countones(wl_s[d]);
                automatic int r = 0;
                automatic logic [7:0] full = 8'((1 << ww(d)) - 1);
                for (int j = 0; j < 32; j++) if (wl_s[d][j]) r = j;
                if (((pe[d] || re[d]) && n > 1) || (pe[d] && re[d])) begin
                    err[d] <= 1'b1;
                end else if (n == 1 && pe[d]) begin
                    rows[d][r] <= bl_s[d] & ((32'd1 << bw(d)) - 1);
                    flags[d]   <= flags[d] | 8'(1 << r);
                    if ((flags[d] | 8'(1 << r)) == full) done[d] <= 1'b1;
                end else if (n == 1 && re[d]) begin
                    rdv[d] <= rows[d][r];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int d = 0; d < 2; d++) begin
                chk("bl_rd", d, act_rd(d), rdv[d]);
                chk("cfg_done", d, 32'(act_done(d)), 32'(done[d]));
                chk("cfg_err", d, 32'(act_err(d)), 32'(err[d]));
                chk("top_out", d, act_top(d), m_top(d));
                chk("left_out", d, act_left(d), m_left(d));
            end
        end
    end

    task automatic step(int d, logic p, logic r, logic [31:0] w, logic [31:0] b);
        @(posedge clk);
        #1;
        for (int e = 0; e < 2; e++) begin
            pe[e] = 1'b0; re[e] = 1'b0; wl_s[e] = '0; bl_s[e] = '0;
            cyt[e] = $urandom; cxl[e] = $urandom; tgp[e] = $urandom; lgp[e] = $urandom;
        end
        pe[d] = p; re[d] = r; wl_s[d] = w; bl_s[d] = b;
    endtask

    task automatic wr(int d, int row, logic [31:0] v); step(d, 1'b1, 1'b0, 32'd1 << row, v); endtask
    task automatic rd(int d, int row); step(d, 1'b0, 1'b1, 32'd1 << row, '0); endtask
    task automatic idle(); step(0, 1'b0, 1'b0, '0, '0); #1; endtask

    initial begin
        logic [8:0] exp9;
        for (int e = 0; e < 2; e++) begin
            pe[e] = 1'b0; re[e] = 1'b0; wl_s[e] = '0; bl_s[e] = '0;
            cyt[e] = '0; cxl[e] = '0; tgp[e] = '0; lgp[e] = '0;
        end
        #1 chk_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_done", 0, 32'(a_done), 0);
        chk("rst_bl_rd", 0, 32'(a_rd), 0);
        chk("rst_top", 0, 32'(a_top), 0);
        rst = 1'b0;

        // All rows 101010: every mux picks in1, but nothing drives until the last row lands.
        for (int r = 0; r < 5; r++) wr(0, r, 32'b101010);
        idle();
        chk("partial_top_zero", 0, 32'(a_top), 0);
        chk("partial_done", 0, 32'(a_done), 0);
        wr(0, 5, 32'b101010);
        idle();
        chk("in1_done", 0, 32'(a_done), 1);
        chk("in1_top0", 0, 32'(a_top[0]), 32'(cxl[0][0]));
        chk("in1_top3", 0, 32'(a_top[3]), 32'(cxl[0][6]));
        chk("in1_left", 0, 32'(a_left), 32'(lgp[0][8:0]));

        // Rewrites after completion: all rows 010101, every mux picks in0.
        for (int r = 0; r < 6; r++) wr(0, r, 32'b010101);
        idle();
        for (int i = 0; i < 9; i++) exp9[i] = cyt[0][(9 - i) % 9];
        chk("in0_top", 0, 32'(a_top), 32'(tgp[0][8:0]));
        chk("in0_left", 0, 32'(a_left), 32'(exp9));

        // Multi-hot write is rejected and flags a sticky error.
        step(0, 1'b1, 1'b0, 32'b000011, 32'h3f);
        idle();
        chk("multihot_err", 0, 32'(a_err), 1);
        rd(0, 0);
        idle();
        chk("rd_row0", 0, 32'(a_rd), 32'b010101);
        rd(0, 1);
        idle();
        chk("rd_row1", 0, 32'(a_rd), 32'b010101);
        chk("err_sticky", 0, 32'(a_err), 1);

        // Row 2 all ones: muxes 6..8 see select 11 and output 0.
        wr(0, 2, 32'h3f);
        step(0, 1'b0, 1'b1, 32'b000100, '0);
        idle();
        chk("rd_row2", 0, 32'(a_rd), 32'h3f);
        chk("mux6_8_zero", 0, 32'(a_top[8:6]), 0);
        step(0, 1'b0, 1'b1, '0, '0);
        idle();

        // Reset mid-use clears everything at once; three rows are not enough to complete.
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_done", 0, 32'(a_done), 0);
        chk("arst_err", 0, 32'(a_err), 0);
        chk("arst_bl_rd", 0, 32'(a_rd), 0);
        chk("arst_top", 0, 32'(a_top), 0);
        chk("arst_left", 0, 32'(a_left), 0);
        #2 rst = 1'b0;
        for (int r = 0; r < 3; r++) wr(0, r, 32'b101010);
        idle();
        chk("three_rows_done", 0, 32'(a_done), 0);

        // Small instance: load, readback, and simultaneous prog/rd error.
        wr(1, 0, 32'b0110);
        wr(1, 1, 32'b1001);
        wr(1, 2, 32'b0101);
        wr(1, 3, 32'b1010);
        idle();
        chk("b_done", 1, 32'(b_done), 1);
        rd(1, 1);
        idle();
        chk("b_rd_row1", 1, 32'(b_rd), 32'b1001);
        step(1, 1'b1, 1'b1, 32'b0001, 32'hf);
        idle();
        chk("b_both_err", 1, 32'(b_err), 1);
        chk("b_both_hold", 1, 32'(b_rd), 32'b1001);
        rd(1, 0);
        idle();
        chk("b_rd_row0", 1, 32'(b_rd), 32'b0110);

        repeat (3) idle();
        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
